// File: rtl/checkpoint_monitor_if.sv
// Checkpoint monitor bus: firmware checkpoint code in, qualified code and sticky status out.
// The monitor owns the slave modport; the firmware/bench side owns the master modport.
interface checkpoint_monitor_if;
    logic [15:0] checkbits;
    logic        code_valid;
    logic [15:0] last_code;
    logic [2:0]  started;
    logic [2:0]  passed;
    logic        done;
    logic        pass;
    logic        fail;
    logic        seq_err;
    logic        timeout;

    modport master (
        output checkbits,
        input  code_valid, last_code, started, passed, done, pass, fail, seq_err, timeout
    );

    modport slave (
        input  checkbits,
        output code_valid, last_code, started, passed, done, pass, fail, seq_err, timeout
    );
endinterface

// File: rtl/checkpoint_monitor.sv
// Debounces a firmware checkpoint bus and tracks the word/short/byte test phases to PASS/FAIL.
// Latency: code_valid one cycle after STABLE_CYCLES equal samples; status one cycle after code_valid; no backpressure.
// Optional CHECKPOINT_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog that ends in the TIMEOUT state.
module checkpoint_monitor #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic               clock,
    input  logic               reset,
    checkpoint_monitor_if.slave mon
);

    localparam logic [3:0] S_WAIT_WORD  = 4'd0;
    localparam logic [3:0] S_WORD       = 4'd1;
    localparam logic [3:0] S_WAIT_SHORT = 4'd2;
    localparam logic [3:0] S_SHORT      = 4'd3;
    localparam logic [3:0] S_WAIT_BYTE  = 4'd4;
    localparam logic [3:0] S_BYTE       = 4'd5;
    localparam logic [3:0] S_PASS       = 4'd6;
    localparam logic [3:0] S_FAIL       = 4'd7;
    localparam logic [3:0] S_TIMEOUT    = 4'd8;

    localparam logic [7:0] STABLE    = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

    logic [15:0] samp_q;
    logic [7:0]  stab_cnt;
    logic [7:0]  stab_nxt;
    logic        match;
    logic        hit;
    logic        accept;

    logic        code_valid_q;
    logic [15:0] last_code_q;

    // A mismatch restarts the count at 1, which is itself a fresh arrival when STABLE_CYCLES is 1.
    always_comb begin
        match    = (mon.checkbits == samp_q);
        hit      = match ? (stab_cnt == STABLE_M1) : (STABLE_CYCLES == 1);
        stab_nxt = match ? ((stab_cnt == STABLE) ? stab_cnt : stab_cnt + 8'd1) : 8'd1;
        accept   = hit && (mon.checkbits != last_code_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            samp_q       <= '0;
            stab_cnt     <= '0;
            code_valid_q <= 1'b0;
            last_code_q  <= '0;
        end else begin
            samp_q       <= mon.checkbits;
            stab_cnt     <= stab_nxt;
            code_valid_q <= accept;
            if (accept)
                last_code_q <= mon.checkbits;
        end
    end

    // Code decode: phase is one-hot {byte,short,word}.
    logic       is_start;
    logic       is_pass;
    logic       is_fail;
    logic [2:0] phase;

    always_comb begin
        is_start = 1'b0;
        is_pass  = 1'b0;
        is_fail  = 1'b0;
        phase    = 3'b000;
        case (last_code_q)
            16'hA040: begin is_start = 1'b1; phase = 3'b001; end
            16'hAB41: begin is_pass  = 1'b1; phase = 3'b001; end
            16'hAB40: begin is_fail  = 1'b1; phase = 3'b001; end
            16'hA020: begin is_start = 1'b1; phase = 3'b010; end
            16'hAB21: begin is_pass  = 1'b1; phase = 3'b010; end
            16'hAB20: begin is_fail  = 1'b1; phase = 3'b010; end
            16'hA010: begin is_start = 1'b1; phase = 3'b100; end
            16'hAB11: begin is_pass  = 1'b1; phase = 3'b100; end
            16'hAB10: begin is_fail  = 1'b1; phase = 3'b100; end
            default:  ;
        endcase
    end

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [2:0] started_q;
    logic [2:0] started_nxt;
    logic [2:0] passed_q;
    logic [2:0] passed_nxt;
    logic       seq_err_q;
    logic       seq_err_nxt;
    logic       done_q;
    logic       pass_q;
    logic       fail_q;
    logic       exp_start;
    logic [2:0] exp_phase;
    logic [3:0] tgt;
    logic       live;
    logic       expire;

    always_comb begin
        exp_start = 1'b0;
        exp_phase = 3'b000;
        tgt       = state;
        live      = 1'b1;
        case (state)
            S_WAIT_WORD:  begin exp_start = 1'b1; exp_phase = 3'b001; tgt = S_WORD;       end
            S_WORD:       begin exp_start = 1'b0; exp_phase = 3'b001; tgt = S_WAIT_SHORT; end
            S_WAIT_SHORT: begin exp_start = 1'b1; exp_phase = 3'b010; tgt = S_SHORT;      end
            S_SHORT:      begin exp_start = 1'b0; exp_phase = 3'b010; tgt = S_WAIT_BYTE;  end
            S_WAIT_BYTE:  begin exp_start = 1'b1; exp_phase = 3'b100; tgt = S_BYTE;       end
            S_BYTE:       begin exp_start = 1'b0; exp_phase = 3'b100; tgt = S_PASS;       end
            default:      live = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        started_nxt = started_q;
        passed_nxt  = passed_q;
        seq_err_nxt = seq_err_q;
        if (live && code_valid_q && (is_start || is_pass || is_fail)) begin
            if (is_fail) begin
                state_nxt = S_FAIL;
            end else if ((exp_start ? is_start : is_pass) && (phase == exp_phase)) begin
                state_nxt = tgt;
                if (is_start)
                    started_nxt = started_q | phase;
                else
                    passed_nxt  = passed_q | phase;
            end else begin
                state_nxt   = S_FAIL;
                seq_err_nxt = 1'b1;
            end
        end
        // An accepted code that lands in a terminal state wins over a coincident expiry.
        if (expire && (state_nxt != S_PASS) && (state_nxt != S_FAIL))
            state_nxt = S_TIMEOUT;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_WAIT_WORD;
            started_q <= '0;
            passed_q  <= '0;
            seq_err_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            started_q <= started_nxt;
            passed_q  <= passed_nxt;
            seq_err_q <= seq_err_nxt;
            done_q    <= (state_nxt == S_PASS) || (state_nxt == S_FAIL) || (state_nxt == S_TIMEOUT);
            pass_q    <= (state_nxt == S_PASS);
            fail_q    <= (state_nxt == S_FAIL) || (state_nxt == S_TIMEOUT);
        end
    end

`ifdef CHECKPOINT_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        timeout_q;

    // tmo_cnt holds the number of elapsed live cycles, so expiry lands on cycle TIMEOUT_CYCLES.
    assign expire = live && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (live)
                tmo_cnt <= tmo_cnt + 32'd1;
            timeout_q <= (state_nxt == S_TIMEOUT);
        end
    end

    assign mon.timeout = timeout_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign expire         = 1'b0;
    assign mon.timeout    = 1'b0;
`endif

    assign mon.code_valid = code_valid_q;
    assign mon.last_code  = last_code_q;
    assign mon.started    = started_q;
    assign mon.passed     = passed_q;
    assign mon.done       = done_q;
    assign mon.pass       = pass_q;
    assign mon.fail       = fail_q;
    assign mon.seq_err    = seq_err_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Directed checks of checkpoint_monitor: debounce, phase sequencing, fail paths, reset and optional watchdog.
module tb_checkpoint_monitor;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   pulses = 0;

    always #5 clock = ~clock;

    checkpoint_monitor_if bus ();

    checkpoint_monitor #(.STABLE_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .mon   (bus)
    );

`ifdef CHECKPOINT_TIMEOUT_EN
    checkpoint_monitor_if bus_t ();

    checkpoint_monitor #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(32'd50)) dut_t (
        .clock (clock),
        .reset (reset),
        .mon   (bus_t)
    );

    initial bus_t.checkbits = 16'h0000;
`endif

    logic [15:0] seq [6] = '{16'hA040, 16'hAB41, 16'hA020, 16'hAB21, 16'hA010, 16'hAB11};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Holds a code for n rising edges, sampling on each following falling edge.
    task automatic hold(input logic [15:0] c, input int n);
        bus.checkbits = c;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (bus.code_valid)
                pulses++;
        end
    endtask

    task automatic do_reset(input logic [15:0] c);
        bus.checkbits = c;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_outs", {4'h0, bus.code_valid, bus.last_code, bus.started, bus.passed,
                           bus.done, bus.pass, bus.fail, bus.seq_err, bus.timeout}, 32'h0);
        reset  = 1'b0;
        pulses = 0;
    endtask

    task automatic run_full(input string tag);
        for (int k = 0; k < 6; k++)
            hold(seq[k], 10);
        chk({tag, "_pulses"},  pulses, 6);
        chk({tag, "_started"}, bus.started, 3'b111);
        chk({tag, "_passed"},  bus.passed, 3'b111);
        chk({tag, "_status"},  {bus.done, bus.pass, bus.fail, bus.seq_err, bus.timeout}, 5'b11000);
        chk({tag, "_last"},    bus.last_code, 16'hAB11);
    endtask

    initial begin
        bus.checkbits = 16'h0000;

`ifdef CHECKPOINT_TIMEOUT_EN
        do_reset(16'h0000);
        hold(16'h0000, 49);
        chk("tmo_before", {bus_t.done, bus_t.fail, bus_t.timeout}, 3'b000);
        hold(16'h0000, 1);
        chk("tmo_at_50", {bus_t.done, bus_t.pass, bus_t.fail, bus_t.timeout}, 4'b1011);
`endif

        // Full pass, with first-code debounce and status latency checked edge by edge.
        do_reset(16'h0000);
        hold(16'hA040, 3);
        chk("early_valid", bus.code_valid, 1'b0);
        hold(16'hA040, 1);
        chk("first_valid", {bus.code_valid, bus.last_code}, {1'b1, 16'hA040});
        chk("status_lag", bus.started, 3'b000);
        hold(16'hA040, 1);
        chk("status_after", {bus.code_valid, bus.started}, {1'b0, 3'b001});
        hold(16'hA040, 5);
        for (int k = 1; k < 6; k++)
            hold(seq[k], 10);
        chk("full_pulses",  pulses, 6);
        chk("full_flags",   {bus.started, bus.passed}, 6'b111_111);
        chk("full_status",  {bus.done, bus.pass, bus.fail, bus.seq_err, bus.timeout}, 5'b11000);

        // Word fail code.
        do_reset(16'h0000);
        hold(16'hA040, 10);
        hold(16'hAB40, 10);
        chk("wfail_status", {bus.done, bus.pass, bus.fail, bus.seq_err}, 4'b1010);
        chk("wfail_flags",  {bus.started, bus.passed}, 6'b001_000);

        // Out-of-order start code.
        do_reset(16'h0000);
        hold(16'hA020, 10);
        chk("seq_status", {bus.done, bus.fail, bus.seq_err}, 3'b111);
        chk("seq_started", bus.started, 3'b000);

        // Unstable bus, then qualification, repeat suppression and unknown codes.
        do_reset(16'h0000);
        for (int k = 0; k < 6; k++) begin
            hold(16'hA040, 2);
            hold(16'h0000, 2);
        end
        chk("toggle_none", pulses, 0);
        hold(16'hA040, 4);
        chk("toggle_one", pulses, 1);
        chk("toggle_last", bus.last_code, 16'hA040);
        hold(16'h0000, 2);
        hold(16'hA040, 6);
        chk("repeat_ignored", {pulses[3:0], bus.seq_err, bus.fail}, {4'd1, 2'b00});
        hold(16'h1234, 6);
        chk("unknown_code", {pulses[3:0], bus.last_code, bus.fail, bus.started}, {4'd2, 16'h1234, 1'b0, 3'b001});

        // Reset mid-qualification discards the partial count.
        do_reset(16'h0000);
        hold(16'hA040, 2);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        hold(16'hA040, 3);
        chk("requal_early", pulses, 0);
        hold(16'hA040, 1);
        chk("requal_done", pulses, 1);

        // Reset while in BYTE, then a clean full run.
        do_reset(16'h0000);
        for (int k = 0; k < 5; k++)
            hold(seq[k], 10);
        chk("byte_flags", {bus.started, bus.passed, bus.done}, {3'b111, 3'b011, 1'b0});
        do_reset(16'h0000);
        run_full("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
